// File: rtl/uart_echo_fifo.sv
// UART echo channel: rx frames -> FIFO -> handshaked tx sequencer, with status counters.
// Build macro UART_ECHO_DROP_ERR_EN: frames received with a frame error are not buffered.

module rx #(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    output logic [FRAME_WD-1:0] rx_data,
    output logic                rx_done,
    output logic                frame_error
);
    localparam int BIT_CNT = CLK_FREQUENCE / BAUD_RATE;
    localparam int PAR_EN  = (PARITY == "NONE") ? 0 : 1;
    localparam bit PAR_ODD = (PARITY == "ODD");
    localparam int CW      = $clog2(BIT_CNT);
    localparam int BW      = $clog2(FRAME_WD + PAR_EN + 2);
    localparam logic [BW-1:0] B_DLAST = BW'(FRAME_WD);
    localparam logic [BW-1:0] B_LAST  = BW'(FRAME_WD + PAR_EN + 1);

    logic [1:0]          r_sync;
    logic                r_busy;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_bit;
    logic [FRAME_WD-1:0] r_shift;
    logic                r_par;
    logic                r_done;
    logic                r_ferr;
    logic                w_in;
    logic                w_par_bad;

    assign w_in      = r_sync[1];
    assign w_par_bad = (PAR_EN != 0) && ((^{r_shift, r_par}) != PAR_ODD);

    // bit index: 0 start, 1..FRAME_WD data, then parity (optional), then stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], uart_rx};
            r_done <= 1'b0;
            if (!r_busy) begin
                if (!w_in) begin
                    r_busy <= 1'b1;
                    r_cnt  <= CW'(BIT_CNT / 2 - 1);
                    r_bit  <= '0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_cnt <= CW'(BIT_CNT - 1);
                r_bit <= r_bit + BW'(1);
                if (r_bit == '0) begin
                    if (w_in) r_busy <= 1'b0;
                end else if (r_bit <= B_DLAST) begin
                    r_shift <= {w_in, r_shift[FRAME_WD-1:1]};
                end else if (r_bit == B_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_ferr <= !w_in || w_par_bad;
                end else begin
                    r_par <= w_in;
                end
            end
        end
    end

    assign rx_data     = r_shift;
    assign rx_done     = r_done;
    assign frame_error = r_ferr;
endmodule

module tx #(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_en,
    input  logic [FRAME_WD-1:0] data_frame,
    output logic                tx_done,
    output logic                uart_tx
);
    localparam int BIT_CNT = CLK_FREQUENCE / BAUD_RATE;
    localparam int PAR_EN  = (PARITY == "NONE") ? 0 : 1;
    localparam bit PAR_ODD = (PARITY == "ODD");
    localparam int CW      = $clog2(BIT_CNT);
    localparam int BW      = $clog2(FRAME_WD + PAR_EN + 2);
    localparam logic [BW-1:0] B_DLAST = BW'(FRAME_WD);
    localparam logic [BW-1:0] B_LAST  = BW'(FRAME_WD + PAR_EN + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit;
    logic          r_tx;
    logic          r_done;
    logic          w_dbit;
    logic          w_par;

    // data is read straight from the port, so the caller holds it for the whole frame
    assign w_dbit = |(data_frame & (FRAME_WD'(1) << r_bit));
    assign w_par  = (^data_frame) ^ PAR_ODD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_bit  <= '0;
            r_tx   <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (frame_en) begin
                    r_busy <= 1'b1;
                    r_tx   <= 1'b0;
                    r_cnt  <= CW'(BIT_CNT - 1);
                    r_bit  <= '0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_cnt <= CW'(BIT_CNT - 1);
                r_bit <= r_bit + BW'(1);
                if (r_bit == B_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else if (r_bit < B_DLAST) begin
                    r_tx <= w_dbit;
                end else if (r_bit == B_DLAST && PAR_EN != 0) begin
                    r_tx <= w_par;
                end else begin
                    r_tx <= 1'b1;
                end
            end
        end
    end

    assign tx_done = r_done;
    assign uart_tx = r_tx;
endmodule

module uart_echo_fifo #(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8,
    parameter int    FIFO_DEPTH    = 16,
    parameter int    CNT_WD        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WD-1:0]             ovf_cnt,
    output logic [CNT_WD-1:0]             err_cnt,
    output logic                          tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    logic [FRAME_WD-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [AW:0]         r_level;
    logic [FRAME_WD-1:0] r_dout;
    logic [FRAME_WD-1:0] r_tx_data;
    state_t              r_state;
    logic                r_frame_en;
    logic                r_busy;
    logic                r_gap;
    logic [CNT_WD-1:0]   r_ovf;
    logic [CNT_WD-1:0]   r_err;

    logic                w_rst_n;
    logic [FRAME_WD-1:0] w_rx_data;
    logic                w_rx_done;
    logic                w_rx_ferr;
    logic                w_tx_done;
    logic                w_uart_tx;
    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic                w_wr;
    logic                w_rd;
    logic                w_ovf;
    logic [AW:0]         w_wptr_nxt;
    logic [AW:0]         w_rptr_nxt;

    assign w_rst_n = !rst;

    rx #(
        .CLK_FREQUENCE(CLK_FREQUENCE),
        .BAUD_RATE    (BAUD_RATE),
        .PARITY       (PARITY),
        .FRAME_WD     (FRAME_WD)
    ) u_rx (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (w_rx_data),
        .rx_done    (w_rx_done),
        .frame_error(w_rx_ferr)
    );

    tx #(
        .CLK_FREQUENCE(CLK_FREQUENCE),
        .BAUD_RATE    (BAUD_RATE),
        .PARITY       (PARITY),
        .FRAME_WD     (FRAME_WD)
    ) u_tx (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .frame_en  (r_frame_en),
        .data_frame(r_tx_data),
        .tx_done   (w_tx_done),
        .uart_tx   (w_uart_tx)
    );

`ifdef UART_ECHO_DROP_ERR_EN
    assign w_accept = !w_rx_ferr;
`else
    assign w_accept = 1'b1;
`endif

    assign w_full  = (r_wptr[AW] != r_rptr[AW])
                  && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_wr    = w_rx_done && !w_full && w_accept;
    assign w_ovf   = w_rx_done && w_full && w_accept;
    // one idle cycle after every frame acts as a stop-bit guard
    assign w_rd    = (r_state == IDLE) && !w_empty && !r_gap;

    assign w_wptr_nxt = r_wptr + (AW+1)'(w_wr);
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_wptr_nxt - w_rptr_nxt;
            if (w_rd) r_dout <= r_mem[r_rptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_frame_en <= 1'b0;
            r_busy     <= 1'b0;
            r_gap      <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_frame_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (!w_empty) begin
                        r_state    <= LOAD;
                        r_frame_en <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    r_tx_data <= r_dout;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (w_tx_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_gap   <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
            r_err <= '0;
        end else begin
            if (w_ovf && r_ovf != '1) r_ovf <= r_ovf + CNT_WD'(1);
            if (w_rx_done && w_rx_ferr && r_err != '1) r_err <= r_err + CNT_WD'(1);
        end
    end

    assign uart_tx    = w_uart_tx;
    assign fifo_level = r_level;
    assign ovf_cnt    = r_ovf;
    assign err_cnt    = r_err;
    assign tx_busy    = r_busy;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: serial stimulus, decoded-echo scoreboard, status checks.
// Expectations for errored frames follow UART_ECHO_DROP_ERR_EN.

module tb_uart_echo_fifo;
    localparam int BIT = 10;

`ifdef UART_ECHO_DROP_ERR_EN
    localparam bit ECHO_BAD = 1'b0;
`else
    localparam bit ECHO_BAD = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       uart_tx;
    logic [2:0] fifo_level;
    logic [3:0] ovf_cnt;
    logic [3:0] err_cnt;
    logic       tx_busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_ovf = 0;
    int         exp_err = 0;
    int         maxlvl = 0;
    bit         trk = 1'b0;
    logic [7:0] q[$];
    logic [7:0] inj_data = 8'h00;
    logic       inj_fe = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       bad;
        logic       echo;
        logic       err;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    uart_echo_fifo #(
        .CLK_FREQUENCE(50_000_000),
        .BAUD_RATE    (5_000_000),
        .PARITY       ("EVEN"),
        .FRAME_WD     (8),
        .FIFO_DEPTH   (4),
        .CNT_WD       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .fifo_level(fifo_level),
        .ovf_cnt   (ovf_cnt),
        .err_cnt   (err_cnt),
        .tx_busy   (tx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic badpar);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ badpar);
        drive_bit(1'b1);
    endtask

    task automatic inject(input logic [7:0] d, input logic fe);
        inj_data = d;
        inj_fe   = fe;
        force dut.w_rx_data = inj_data;
        force dut.w_rx_ferr = inj_fe;
        force dut.w_rx_done = 1'b1;
        @(negedge clk);
        release dut.w_rx_done;
        release dut.w_rx_data;
        release dut.w_rx_ferr;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic probe(input int s);
        case (s)
            0:       return dut.w_rx_done;
            1:       return dut.r_frame_en;
            default: return dut.w_tx_done;
        endcase
    endfunction

    task automatic wait_ev(input int s, input int lim);
        int n = 0;
        while (probe(s) !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (probe(s) !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_ev%0d: no event within %0d cycles", s, lim);
        end
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while ((q.size() != 0 || tx_busy !== 1'b0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || tx_busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d busy=%b expected 0/0", q.size(), tx_busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // serial decoder; frames cut short by reset are discarded
    initial begin : mon
        logic [7:0] got;
        logic [7:0] e;
        logic       par;
        logic       stp;
        bit         ab;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                ab = 1'b0;
                wait_cyc(4, ab);
                for (int i = 0; i < 8; i++) begin
                    wait_cyc(BIT, ab);
                    got[i] = uart_tx;
                end
                wait_cyc(BIT, ab);
                par = uart_tx;
                wait_cyc(BIT, ab);
                stp = uart_tx;
                if (!ab) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL echo_unexpected: got %02h expected none", got);
                    end else begin
                        e = q.pop_front();
                        chk("echo_data", got, e);
                        chk("echo_par", par, ^e);
                        chk("echo_stop", stp, 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (trk && int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{d: 8'h00, bad: 1'b0, echo: 1'b1,     err: 1'b0};
        vt[1] = '{d: 8'hFF, bad: 1'b0, echo: 1'b1,     err: 1'b0};
        vt[2] = '{d: 8'h3C, bad: 1'b1, echo: ECHO_BAD, err: 1'b1};
        vt[3] = '{d: 8'h3C, bad: 1'b0, echo: 1'b1,     err: 1'b0};
        vt[4] = '{d: 8'h81, bad: 1'b1, echo: ECHO_BAD, err: 1'b1};
        vt[5] = '{d: 8'h7E, bad: 1'b0, echo: 1'b1,     err: 1'b0};
        vt[6] = '{d: 8'h55, bad: 1'b0, echo: 1'b1,     err: 1'b0};
        vt[7] = '{d: 8'hC3, bad: 1'b1, echo: ECHO_BAD, err: 1'b1};

        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", tx_busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single echo with cycle-level timing
        q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b0);
        join_none
        wait_ev(0, 300);
        @(negedge clk);
        chk("lvl_T1", fifo_level, 1);
        chk("fen_T1", dut.r_frame_en, 0);
        @(negedge clk);
        chk("fen_T2", dut.r_frame_en, 1);
        chk("lvl_T2", fifo_level, 0);
        chk("busy_T2", tx_busy, 1);
        @(negedge clk);
        chk("fen_pulse", dut.r_frame_en, 0);
        wait_ev(2, 300);
        @(negedge clk);
        chk("busy_W1", tx_busy, 0);
        wait_drain(400);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].echo) q.push_back(vt[i].d);
            if (vt[i].err) exp_err++;
            send_frame(vt[i].d, vt[i].bad);
            repeat (3) @(negedge clk);
            chk($sformatf("err_cnt_v%0d", i), err_cnt, exp_err);
            wait_drain(400);
            chk($sformatf("level_v%0d", i), fifo_level, 0);
            chk($sformatf("ovf_v%0d", i), ovf_cnt, exp_ovf);
        end

        // burst: one in flight, four buffered, sixth dropped
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) q.push_back(8'(i));
            else exp_ovf++;
            inject(8'(i), 1'b0);
        end
        chk("burst_ovf", ovf_cnt, exp_ovf);
        chk("burst_level", fifo_level, 4);
        wait_ev(2, 300);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (dut.r_frame_en !== 1'b1 && n < 8);
            chk("fen_after_txdone", n, 3);
        end
        wait_drain(1000);
        chk("burst_level_end", fifo_level, 0);

        // errored frame arriving while full, then counter saturation
        for (int i = 0; i < 5; i++) begin
            q.push_back(8'h10 + 8'(i));
            inject(8'h10 + 8'(i), 1'b0);
        end
        exp_err++;
        if (ECHO_BAD) exp_ovf++;
        inject(8'hEE, 1'b1);
        chk("full_err_err", err_cnt, exp_err);
        chk("full_err_ovf", ovf_cnt, exp_ovf);
        for (int i = 0; i < 20; i++) begin
            exp_ovf = (exp_ovf < 15) ? exp_ovf + 1 : 15;
            inject(8'hE0 + 8'(i), 1'b0);
            if (i == 9) chk("sat_mid", ovf_cnt, exp_ovf);
        end
        chk("sat_ovf", ovf_cnt, exp_ovf);
        chk("sat_level", fifo_level, 4);
        wait_drain(1000);

        // reset during bit 4 of an echo
        fork
            send_frame(8'h66, 1'b0);
        join_none
        wait_ev(1, 400);
        repeat (55) @(negedge clk);
        chk("tx_bit4_pre", uart_tx, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", uart_tx, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ovf", ovf_cnt, 0);
        chk("mid_rst_err", err_cnt, 0);
        exp_ovf = 0;
        exp_err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0);
        wait_drain(400);

        // pointer wrap: twelve frames spaced one frame time apart
        maxlvl = 0;
        trk    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            q.push_back(8'h30 + 8'(i));
            send_frame(8'h30 + 8'(i), 1'b0);
            drive_bit(1'b1);
        end
        wait_drain(600);
        trk = 1'b0;
        chk("wrap_maxlvl_le2", maxlvl <= 2, 1);
        chk("wrap_level", fifo_level, 0);
        chk("end_queue", q.size(), 0);
        chk("end_ovf", ovf_cnt, exp_ovf);
        chk("end_err", err_cnt, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised UART echo channel: frames received on `uart_rx` are buffered in an internal synchronous FIFO and re-transmitted on `uart_tx` by a handshaked transmit sequencer. It sits at the top of the UART subsystem and instantiates the existing `rx` and `tx` blocks. It replaces the vendor FIFO with an in-house FIFO of configurable depth. It reports status: fill level, overflow count and error count.

## Interface
- `CLK_FREQUENCE`, 50_000_000, system clock in Hz; passed to `rx` and `tx`
- `BAUD_RATE`, 9600, line rate; passed to `rx` and `tx`
- `PARITY`, "NONE", "NONE"/"EVEN"/"ODD"; passed to `rx` and `tx`
- `FRAME_WD`, 8, data bits per frame
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥2
- `CNT_WD`, 8, width of the saturating status counters
- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous, active-high; `rx`/`tx` receive `!rst` on their `rst_n`
- `uart_rx`  in  1  serial input; idle high
- `uart_tx`  out  1  serial output; idle high
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently stored
- `ovf_cnt`  out  CNT_WD  frames lost because the FIFO was full; saturating
- `err_cnt`  out  CNT_WD  frames received with `frame_error`; saturating
- `tx_busy`  out  1  high whenever the sequencer is not in IDLE

## Operation
- Reset values: `uart_tx`=1, `fifo_level`=0, `ovf_cnt`=0, `err_cnt`=0, `tx_busy`=0, state=IDLE, pointers=0.
- FIFO: binary read/write pointers with one extra wrap bit. Full is asserted when the pointers differ only in the MSB. Empty is asserted when the pointers are equal. `fifo_level` is the registered pointer difference.
- Write: `wr = rx_done & !full & accept`. `accept` is defined under Configuration.
- `rx_done & full`: the frame is dropped and `ovf_cnt` increments. Counters saturate at 2^CNT_WD-1.
- `rx_done & frame_error` increments `err_cnt` in both configurations.
- Read: registered output. The entry is available in the data holding register the cycle after `rd`.
- Sequencer FSM:
  - IDLE: if `!empty`, assert `rd` and go to LOAD.
  - LOAD: latch the FIFO output into `tx_data`, pulse `frame_en` for exactly 1 cycle, go to WAIT.
  - WAIT: hold `tx_data` stable. On `tx_done`, go to IDLE.
- At most one frame is in flight. `frame_en` is never asserted while in WAIT.
- Simultaneous write and read are both performed. The level stays unchanged.
- A write while full is blocked even if a read occurs the same cycle; the full flag is sampled before the edge.
- Pointers wrap modulo FIFO_DEPTH through the wrap bit, with no special casing.
- `rst` mid-frame: all state clears immediately and asynchronously. The in-flight frame and FIFO contents are lost. `uart_tx` returns high.

## Timing
- `rx_done` at cycle T with an empty FIFO and IDLE sequencer:
  - write at edge T
  - `fifo_level`=1 at T+1
  - `rd` at T+1
  - state LOAD and `frame_en` high at T+2
  - `fifo_level`=0 at T+2
- `tx_done` at cycle W gives IDLE at W+1. If the FIFO is non-empty, the next `frame_en` is at W+3.
- Back-to-back `rx_done` pulses at most one per frame time; each is accepted in its own cycle.
- Status outputs update one cycle after the causing event.

## Configuration
- `UART_ECHO_DROP_ERR_EN`
  - Defined: `accept = !frame_error`. Errored frames are not written, and are not counted in `ovf_cnt` even if the FIFO is full.
  - Undefined: `accept = 1`. Errored frames are buffered and echoed like good frames.

## Test plan
Simulation settings: CLK_FREQUENCE=50_000_000, BAUD_RATE=5_000_000 (10 clk/bit), FIFO_DEPTH=4, CNT_WD=4.
- Single echo: drive 0xA5 on `uart_rx` → `frame_en` exactly 2 cycles after `rx_done`; `uart_tx` shows 0xA5 LSB-first; `fifo_level` returns to 0; `tx_busy` low after `tx_done`.
- Burst fill: send 0x01..0x06 back-to-back → first byte in flight, bytes 2..5 fill the FIFO, byte 6 dropped; `ovf_cnt`=1; output sequence 0x01..0x05.
- Saturation: force 20 overflows → `ovf_cnt` holds at 15.
- Parity error, PARITY="EVEN", send 0x3C with a bad parity bit:
  - with macro: `err_cnt`=1, nothing echoed
  - without macro: `err_cnt`=1, 0x3C echoed
- Reset mid-transmit: assert `rst` during bit 4 of the echo → `uart_tx`=1 within the same cycle; all outputs at reset values; the next frame 0x5A is echoed correctly.
- Wrap: stream 12 frames spaced one frame time apart → all echoed in order; pointers wrap 3 times; `fifo_level` never exceeds 2.
